// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: sequential or branch target, plus a misalignment flag.
module pc_next
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            pc_src,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Modulo-2^XLEN arithmetic; wrap-around is intentional.
    always_comb begin
        next_pc    = pc_src ? (instr_pc + imm_ext) : (instr_pc + XLEN'(PC_INC));
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the fetched word until the decode/execute stage accepts it.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .instr_pc   (instr_pc_q),
        .imm_ext    (ImmExt),
        .pc_src     (PCSrc),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d    = HOLD;
                    instr_d    = imem_resp_data;
                    instr_pc_d = pc_q;
                end
            end
            HOLD: begin
                // A bad target halts fetch without disturbing pc.
                if (instr_ready) begin
                    if (next_misaligned) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_NOP;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            fault_q    <= fault_d;
        end
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        imem_req_valid = (state_q == REQ);
        instr_valid    = (state_q == HOLD);
        imem_req_addr  = (state_q == FAULT) ? '0 : pc_q;
        instr          = (state_q == FAULT) ? '0 : instr_q;
        instr_pc       = (state_q == FAULT) ? '0 : instr_pc_q;
        fetch_fault    = fault_q;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle RISC-V core. It owns the program counter, issues one request at a time to instruction memory, and holds each fetched instruction with its PC until the decode/execute stage accepts it. Decode and execute drive `control_unit`. On acceptance, the stage computes the next PC from the branch decision (`PCSrc`) and the immediate (`ImmExt`) supplied by that stage.

## Interface
Parameters:
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, PC loaded by reset; must be 4-byte aligned

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  fetch address (= `pc`)
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_resp_valid`  in  1  response data valid
- `imem_resp_data`  in  32  fetched instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` valid for consumer
- `instr`  out  32  held instruction
- `instr_pc`  out  XLEN  PC of held instruction
- `instr_ready`  in  1  consumer accepts held instruction
- `PCSrc`  in  1  branch taken for the held instruction; sampled only on accept
- `ImmExt`  in  XLEN  sign-extended branch offset; sampled only on accept
- `fetch_fault`  out  1  sticky misaligned-target flag

## Operation
- FSM states:
  - REQ: drive `imem_req_valid`=1.
  - WAIT: await response.
  - HOLD: `instr_valid`=1.
  - FAULT: halted.
- REQ → WAIT when `imem_req_ready`=1. Otherwise stay in REQ. `imem_req_addr` must remain stable while in REQ.
- WAIT → HOLD on `imem_resp_valid`=1. On that edge, latch `instr`←`imem_resp_data` and `instr_pc`←`pc`. `imem_resp_valid` is ignored in every state other than WAIT.
- HOLD: `instr`/`instr_pc` are held stable until `instr_ready`=1. On accept, compute `next = PCSrc ? instr_pc + ImmExt : instr_pc + 4`.
  - If `next[1:0]`≠0: `fetch_fault`←1, go to FAULT, and leave `pc` unchanged.
  - Otherwise: `pc`←`next`, go to REQ.
- FAULT: every output except `fetch_fault` is deasserted. Only `rst` leaves this state.
- Arithmetic is modulo 2^XLEN: PC+4 from 32'hFFFF_FFFC wraps to 0, and negative `ImmExt` wraps normally.
- Only one request is outstanding at a time. A redirect can occur only in HOLD, so no in-flight response is ever killed.
- Instruction memory shares `rst`, so no stale response exists after reset.

## Timing
- During `rst`=1 (synchronous): `pc`←`RESET_PC`, state←REQ, `instr`←32'h0000_0013 (NOP), `instr_pc`←0, `fetch_fault`←0.
- Output values during reset:
  - `instr_valid`=0.
  - `imem_req_valid`=1 in the first cycle with `rst`=0, with `imem_req_addr`=`RESET_PC`.
  - During the reset cycle itself, outputs follow state REQ only after the edge.
- Minimum latency with zero-wait memory is 3 cycles per instruction:
  - cycle n: REQ handshake
  - cycle n+1: WAIT with `imem_resp_valid`=1
  - cycle n+2: HOLD with `instr_valid`=1; if `instr_ready`=1, the next REQ is at n+3
- `imem_req_valid` and `instr_valid` are decoded from registered state only, with no combinational path from inputs. `PCSrc`/`ImmExt` feed only the next-PC register.
- `rst` asserted in any state, including WAIT or HOLD mid-handshake, wins over all other events in that cycle. The held instruction is discarded.
- Back-pressure: `instr_ready` low for k cycles extends HOLD by k cycles. There is no fetch-ahead.

## Structure
- Shared package `riscv_pkg`:
  - `fetch_state_t` enum (REQ, WAIT, HOLD, FAULT)
  - `INSTR_NOP` = 32'h0000_0013
  - `PC_INC` = 4
- One sub-module `pc_next`: purely combinational `{instr_pc, ImmExt, PCSrc} → {next, misaligned}`. It is reused later for jump targets.
- The FSM and the `pc`/`instr`/`instr_pc` registers live in `fetch_unit`.

## Test plan
- Reset release with `RESET_PC`=32'h100 and zero-wait memory returning 32'h00500093 → `imem_req_addr`=0x100 in cycle 1; `instr_valid`=1 with `instr`=32'h00500093 and `instr_pc`=0x100 in cycle 3; next request at 0x104.
- Taken branch: held `instr_pc`=0x200, `PCSrc`=1, `ImmExt`=32'hFFFF_FFF8 on accept → next `imem_req_addr`=0x1F8. With `PCSrc`=0, the next address is 0x204.
- Back-pressure: `instr_ready` low 5 cycles in HOLD → `instr`/`instr_pc` unchanged, `imem_req_valid`=0 throughout; request issues the cycle after accept.
- Memory stalls: `imem_req_ready` low 3 cycles, then response delayed 4 cycles, plus a spurious `imem_resp_valid` pulse while in REQ → address stable during the stall, the spurious pulse is ignored, and exactly one instruction is delivered.
- Misaligned target: `instr_pc`=0x10, `PCSrc`=1, `ImmExt`=6 → `fetch_fault`=1, no further requests. Then `rst` → fault clears and fetch restarts at `RESET_PC`.
- Wrap plus mid-operation reset: `instr_pc`=32'hFFFF_FFFC, `PCSrc`=0 → next address 0. Assert `rst` in WAIT → the response is dropped and REQ restarts at `RESET_PC` with `instr_valid`=0.
